// File: rtl/sccpu_pkg.sv
// Shared opcode/funct encodings and control enums for the single-cycle MIPS-subset CPU.
package sccpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluNor, AluSlt, AluSltu,
        AluSll, AluSrl, AluSra, AluLui
    } alu_op_e;

    typedef enum logic [1:0] {PcPlus4, PcBranch, PcJump, PcJr} pc_src_e;

endpackage

// File: rtl/dm.sv
// Data RAM: synchronous write, combinational read, never cleared by reset.
module dm #(
    parameter int unsigned DM_DEPTH = 128,
    parameter int unsigned DM_AW    = $clog2(DM_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DM_AW-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] RAM [0:DM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            RAM[idx] <= wdata;
        end
    end

    assign rdata = RAM[idx];

endmodule

// File: rtl/im.sv
// Instruction ROM, word-addressed; contents are loaded from outside the design.
module im #(
    parameter int unsigned IM_DEPTH = 128,
    parameter int unsigned IM_AW    = $clog2(IM_DEPTH)
) (
    input  logic [IM_AW-1:0] addr,
    output logic [31:0]      dout
);

    logic [31:0] ROM [0:IM_DEPTH-1];

    assign dout = ROM[addr];

endmodule

// File: rtl/sccpu.sv
// Single-cycle core: PC, decoder, register file and ALU; one instruction commits per edge.
module sccpu
    import sccpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DM_AW    = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      instr,
    output logic [31:0]      pc,
    output logic             mem_we,
    output logic [DM_AW-1:0] mem_idx,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic [4:0]       reg_sel,
    output logic [31:0]      reg_data
);

    logic [31:0] pc_q, pc_d, pc4;
    logic [31:0] rf_q [1:31];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] rs_val, rt_val, imm_se, imm_ext, alu_b, alu_y, wd;

    alu_op_e     alu_op;
    pc_src_e     pc_src;
    logic        alu_src_imm, imm_zext, reg_we, dec_mem_we, wb_mem, wb_link;
    logic [4:0]  wa;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];

    assign pc      = pc_q;
    assign pc4     = pc_q + 32'd4;
    assign rs_val  = (rs == 5'd0) ? '0 : rf_q[rs];
    assign rt_val  = (rt == 5'd0) ? '0 : rf_q[rt];
    assign imm_se  = {{16{imm[15]}}, imm};
    assign imm_ext = imm_zext ? {16'h0000, imm} : imm_se;
    assign alu_b   = alu_src_imm ? imm_ext : rt_val;

    always_comb begin
        alu_op      = AluAdd;
        alu_src_imm = 1'b0;
        imm_zext    = 1'b0;
        reg_we      = 1'b0;
        wa          = rd;
        dec_mem_we  = 1'b0;
        wb_mem      = 1'b0;
        wb_link     = 1'b0;
        pc_src      = PcPlus4;
        case (op)
            OP_RTYPE: begin
                reg_we = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = AluAdd;
                    FN_SUB, FN_SUBU: alu_op = AluSub;
                    FN_AND:          alu_op = AluAnd;
                    FN_OR:           alu_op = AluOr;
                    FN_NOR:          alu_op = AluNor;
                    FN_SLT:          alu_op = AluSlt;
                    FN_SLTU:         alu_op = AluSltu;
                    FN_SLL:          alu_op = AluSll;
                    FN_SRL:          alu_op = AluSrl;
                    FN_SRA:          alu_op = AluSra;
                    FN_JR: begin
                        reg_we = 1'b0;
                        pc_src = PcJr;
                    end
                    default:         reg_we = 1'b0;
                endcase
            end
            OP_ADDI: begin
                alu_src_imm = 1'b1; reg_we = 1'b1; wa = rt;
            end
            OP_ANDI: begin
                alu_op = AluAnd; alu_src_imm = 1'b1; imm_zext = 1'b1; reg_we = 1'b1; wa = rt;
            end
            OP_ORI: begin
                alu_op = AluOr; alu_src_imm = 1'b1; imm_zext = 1'b1; reg_we = 1'b1; wa = rt;
            end
            OP_LUI: begin
                alu_op = AluLui; reg_we = 1'b1; wa = rt;
            end
            OP_LW: begin
                alu_src_imm = 1'b1; reg_we = 1'b1; wa = rt; wb_mem = 1'b1;
            end
            OP_SW: begin
                alu_src_imm = 1'b1; dec_mem_we = 1'b1;
            end
            OP_BEQ:  if (rs_val == rt_val) pc_src = PcBranch;
            OP_BNE:  if (rs_val != rt_val) pc_src = PcBranch;
            OP_J:    pc_src = PcJump;
            OP_JAL: begin
                pc_src = PcJump; reg_we = 1'b1; wa = 5'd31; wb_link = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_y = '0;
        case (alu_op)
            AluAdd:  alu_y = rs_val + alu_b;
            AluSub:  alu_y = rs_val - alu_b;
            AluAnd:  alu_y = rs_val & alu_b;
            AluOr:   alu_y = rs_val | alu_b;
            AluNor:  alu_y = ~(rs_val | alu_b);
            AluSlt:  alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
            AluSltu: alu_y = {31'd0, rs_val < alu_b};
            AluSll:  alu_y = rt_val << shamt;
            AluSrl:  alu_y = rt_val >> shamt;
            AluSra:  alu_y = $signed(rt_val) >>> shamt;
            AluLui:  alu_y = {imm, 16'h0000};
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        pc_d = pc4;
        case (pc_src)
            PcBranch: pc_d = pc4 + {imm_se[29:0], 2'b00};
            PcJump:   pc_d = {pc4[31:28], instr[25:0], 2'b00};
            PcJr:     pc_d = rs_val;
            default:  pc_d = pc4;
        endcase
    end

    assign wd = wb_link ? pc4 : (wb_mem ? mem_rdata : alu_y);

    // Stores are suppressed while reset is held so RAM survives a reset.
    assign mem_we    = dec_mem_we & rstn;
    assign mem_idx   = alu_y[DM_AW+1:2];
    assign mem_wdata = rt_val;
    assign reg_data  = (reg_sel == 5'd0) ? '0 : rf_q[reg_sel];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q <= RESET_PC;
            for (int i = 1; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d;
            if (reg_we && (wa != 5'd0)) begin
                rf_q[wa] <= wd;
            end
        end
    end

endmodule

// File: rtl/sccomp.sv
// Single-cycle computer top: core plus instruction ROM and data RAM, with register read-back.
module sccomp #(
    parameter int unsigned IM_DEPTH = 128,
    parameter int unsigned DM_DEPTH = 128,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data
);

    localparam int unsigned IM_AW = $clog2(IM_DEPTH);
    localparam int unsigned DM_AW = $clog2(DM_DEPTH);

    logic [31:0]      PC;
    logic [31:0]      instr;
    logic             dm_we;
    logic [DM_AW-1:0] dm_idx;
    logic [31:0]      dm_wdata;
    logic [31:0]      dm_rdata;

    im #(
        .IM_DEPTH (IM_DEPTH),
        .IM_AW    (IM_AW)
    ) U_IM (
        .addr (PC[IM_AW+1:2]),
        .dout (instr)
    );

    sccpu #(
        .RESET_PC (RESET_PC),
        .DM_AW    (DM_AW)
    ) U_CPU (
        .clk       (clk),
        .rstn      (rstn),
        .instr     (instr),
        .pc        (PC),
        .mem_we    (dm_we),
        .mem_idx   (dm_idx),
        .mem_wdata (dm_wdata),
        .mem_rdata (dm_rdata),
        .reg_sel   (reg_sel),
        .reg_data  (reg_data)
    );

    dm #(
        .DM_DEPTH (DM_DEPTH),
        .DM_AW    (DM_AW)
    ) U_DM (
        .clk   (clk),
        .we    (dm_we),
        .idx   (dm_idx),
        .wdata (dm_wdata),
        .rdata (dm_rdata)
    );

endmodule

// File: tb/tb_sccomp.sv
// Bench for sccomp: directed program with literal expectations, then random programs
// checked every cycle against an instruction-level architectural model.
module tb_sccomp;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [4:0]  reg_sel = 5'd0;
    logic [31:0] reg_data;

    int checks = 0;
    int errors = 0;

    sccomp dut (
        .clk      (clk),
        .rstn     (rstn),
        .reg_sel  (reg_sel),
        .reg_data (reg_data)
    );

    always #50 clk = ~clk;

    // Architectural model state.
    logic [31:0] rom     [0:127];
    logic [31:0] dm_seed [0:127];
    logic [31:0] m_mem   [0:127];
    logic [31:0] m_regs  [0:31];
    logic [31:0] m_pc;
    logic        load_mem = 1'b0;

    typedef struct packed {
        logic [31:0] npc;
        logic        rwe;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        mwe;
        logic [6:0]  midx;
        logic [31:0] md;
    } eff_t;

    // Effect of one instruction given PC, its rs/rt values and the loaded word.
    function automatic eff_t exec(input logic [31:0] pc, input logic [31:0] ins,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] ld);
        eff_t        e;
        logic [31:0] pc4, se, ze, addr;
        logic [4:0]  rt, rd, sh;
        pc4  = pc + 32'd4;
        se   = {{16{ins[15]}}, ins[15:0]};
        ze   = {16'h0000, ins[15:0]};
        rt   = ins[20:16];
        rd   = ins[15:11];
        sh   = ins[10:6];
        addr = a + se;
        e      = '0;
        e.npc  = pc4;
        e.md   = b;
        e.midx = addr[8:2];
        case (ins[31:26])
            6'h00: begin
                e.rwe = 1'b1;
                e.wa  = rd;
                case (ins[5:0])
                    6'h20, 6'h21: e.wd = a + b;
                    6'h22, 6'h23: e.wd = a - b;
                    6'h24: e.wd = a & b;
                    6'h25: e.wd = a | b;
                    6'h27: e.wd = ~(a | b);
                    6'h2A: e.wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: e.wd = (a < b) ? 32'd1 : 32'd0;
                    6'h00: e.wd = b << sh;
                    6'h02: e.wd = b >> sh;
                    6'h03: e.wd = $signed(b) >>> sh;
                    6'h08: begin e.rwe = 1'b0; e.npc = a; end
                    default: e.rwe = 1'b0;
                endcase
            end
            6'h08: begin e.rwe = 1'b1; e.wa = rt; e.wd = a + se; end
            6'h0C: begin e.rwe = 1'b1; e.wa = rt; e.wd = a & ze; end
            6'h0D: begin e.rwe = 1'b1; e.wa = rt; e.wd = a | ze; end
            6'h0F: begin e.rwe = 1'b1; e.wa = rt; e.wd = {ins[15:0], 16'h0000}; end
            6'h23: begin e.rwe = 1'b1; e.wa = rt; e.wd = ld; end
            6'h2B: e.mwe = 1'b1;
            6'h04: if (a == b) e.npc = pc4 + (se << 2);
            6'h05: if (a != b) e.npc = pc4 + (se << 2);
            6'h02: e.npc = {pc4[31:28], ins[25:0], 2'b00};
            6'h03: begin
                e.npc = {pc4[31:28], ins[25:0], 2'b00};
                e.rwe = 1'b1; e.wa = 5'd31; e.wd = pc4;
            end
            default: ;
        endcase
        return e;
    endfunction

    logic [31:0] m_ins, m_a, m_b, m_addr, m_ld;
    eff_t        m_eff;
    assign m_ins  = rom[m_pc[8:2]];
    assign m_a    = m_regs[m_ins[25:21]];
    assign m_b    = m_regs[m_ins[20:16]];
    assign m_addr = m_a + {{16{m_ins[15]}}, m_ins[15:0]};
    assign m_ld   = m_mem[m_addr[8:2]];
    assign m_eff  = exec(m_pc, m_ins, m_a, m_b, m_ld);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pc <= 32'h0000_0000;
            for (int i = 0; i < 32; i++) m_regs[i] <= '0;
            if (load_mem) begin
                for (int i = 0; i < 128; i++) m_mem[i] <= dm_seed[i];
            end
        end else begin
            m_pc <= m_eff.npc;
            if (m_eff.rwe && (m_eff.wa != 5'd0)) m_regs[m_eff.wa] <= m_eff.wd;
            if (m_eff.mwe) m_mem[m_eff.midx] <= m_eff.md;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [4:0] r, output logic [31:0] v);
        reg_sel = r;
        #1;
        v = reg_data;
    endtask

    task automatic chk_reg(input string name, input logic [4:0] r, input logic [31:0] exp);
        logic [31:0] v;
        rd(r, v);
        check(name, v, exp);
    endtask

    // Compare PC, fetched word and the whole register file against the model.
    task automatic compare_all();
        check("pc", dut.PC, m_pc);
        check("instr", dut.instr, m_ins);
        for (int i = 0; i < 32; i++) begin
            reg_sel = i[4:0];
            #1;
            check($sformatf("rf[%0d]", i), reg_data, m_regs[i]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_rom(input int i, input logic [31:0] w);
        rom[i] = w;
        dut.U_IM.ROM[i] = w;
    endtask

    // Seed data RAM identically in DUT and model; must be called with reset held.
    task automatic load_dm();
        for (int i = 0; i < 128; i++) begin
            dm_seed[i] = $urandom;
            dut.U_DM.RAM[i] = dm_seed[i];
        end
        load_mem = 1'b1;
        @(posedge clk);
        #1;
        load_mem = 1'b0;
    endtask

    logic [5:0] fn_tab [0:14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A,
                                  6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h3F};
    logic [5:0] op_tab [0:11] = '{6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05,
                                  6'h02, 6'h03, 6'h3F, 6'h01};

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 2) == 0) begin
            return {6'h00, r[25:6], fn_tab[$urandom_range(0, 14)]};
        end
        return {op_tab[$urandom_range(0, 11)], r[25:0]};
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) set_rom(i, 32'h0000_0000);
        set_rom(0, 32'h3C01_1234);  // lui  $1,0x1234
        set_rom(1, 32'h3402_0005);  // ori  $2,$0,5
        set_rom(2, 32'h0002_1900);  // sll  $3,$2,4
        set_rom(3, 32'h0023_3821);  // addu $7,$1,$3
        set_rom(4, 32'hAC07_0000);  // sw   $7,0($0)
        set_rom(5, 32'h8C08_0000);  // lw   $8,0($0)
        set_rom(6, 32'h14E8_0001);  // bne  $7,$8,+1 (equal: falls through)
        set_rom(7, 32'h14E1_0001);  // bne  $7,$1,+1 (unequal: taken)
        set_rom(8, 32'h3C09_DEAD);  // lui  $9 (skipped)
        set_rom(9, 32'h1000_FFFF);  // beq  $0,$0,-1

        #1 rstn = 1'b0;
        #1 check("reset_pc_async", dut.PC, 32'h0000_0000);
        chk_reg("reset_rf1", 5'd1, 32'h0);
        compare_all();
        load_dm();
        @(posedge clk);
        #50 rstn = 1'b1;

        cycle();
        check("lui_pc", dut.PC, 32'h0000_0004);
        chk_reg("lui_rf1", 5'd1, 32'h1234_0000);
        cycle();
        cycle();
        check("sll_pc", dut.PC, 32'h0000_000C);
        chk_reg("sll_rf3", 5'd3, 32'h0000_0050);
        cycle();
        chk_reg("addu_rf7", 5'd7, 32'h1234_0050);
        chk_reg("read_r0", 5'd0, 32'h0000_0000);
        cycle();
        cycle();
        chk_reg("lw_rf8", 5'd8, 32'h1234_0050);
        cycle();
        check("bne_fallthru_pc", dut.PC, 32'h0000_001C);
        cycle();
        check("bne_taken_pc", dut.PC, 32'h0000_0024);
        repeat (5) begin
            cycle();
            check("beq_loop_pc", dut.PC, 32'h0000_0024);
            chk_reg("beq_loop_rf9", 5'd9, 32'h0);
            chk_reg("beq_loop_rf7", 5'd7, 32'h1234_0050);
        end

        @(posedge clk);
        #10 rstn = 1'b0;
        #1 check("midrst_pc", dut.PC, 32'h0000_0000);
        chk_reg("midrst_rf7", 5'd7, 32'h0);
        chk_reg("midrst_rf1", 5'd1, 32'h0);
        #47 rstn = 1'b1;
        cycle();
        check("restart_pc", dut.PC, 32'h0000_0004);
        chk_reg("restart_rf1", 5'd1, 32'h1234_0000);
        chk_reg("restart_rf7", 5'd7, 32'h0);

        for (int p = 0; p < 4; p++) begin
            rstn = 1'b0;
            for (int i = 0; i < 128; i++) set_rom(i, rand_instr());
            load_dm();
            @(negedge clk);
            rstn = 1'b1;
            repeat (250) cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
